// File: rtl/lut_config_loader.sv
`default_nettype none
// ============================================================================
// Module  : lut_config_loader
// Brief   : Assembles word-serial bitstream beats into LUT frames and commits
//           them one LUT at a time. Optional LOADER_PARITY_EN adds a parity beat.
// Rev     : 1.0
// ============================================================================
module lut_config_loader #(
   parameter int MEM_SIZE     = 16,
   parameter int CONFIG_WIDTH = 4,
   parameter int NUM_LUTS     = 4
) (
   input  logic                    config_clk,
   input  logic                    config_rst,
   input  logic                    start,
   input  logic                    bs_valid,
   input  logic [CONFIG_WIDTH-1:0] bs_data,
   output logic                    bs_ready,
   output logic [MEM_SIZE-1:0]     config_data,
   output logic [NUM_LUTS-1:0]     config_en,
   output logic                    busy,
   output logic                    done,
   output logic                    error
);

   localparam int WORDS = MEM_SIZE / CONFIG_WIDTH;
   localparam int BW    = (WORDS > 1) ? $clog2(WORDS) : 1;
   localparam int IW    = (NUM_LUTS > 1) ? $clog2(NUM_LUTS) : 1;

   localparam logic [BW-1:0]       c_LAST_BEAT = BW'(WORDS - 1);
   localparam logic [IW-1:0]       c_LAST_LUT  = IW'(NUM_LUTS - 1);
   localparam logic [NUM_LUTS-1:0] c_EN_ONE    = NUM_LUTS'(1);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_SHIFT  = 3'd1,
      S_PARITY = 3'd2,
      S_COMMIT = 3'd3,
      S_DONE   = 3'd4
   } state_t;

   state_t                r_state;
   state_t                w_state_nxt;
   logic [BW-1:0]         r_beat;
   logic [IW-1:0]         r_idx;
   logic [MEM_SIZE-1:0]   r_config_data;
   logic [NUM_LUTS-1:0]   r_config_en;
   logic                  r_done;
   logic                  w_start_ok;

   // A start coinciding with the done pulse belongs to the finished load.
   assign w_start_ok = start && !r_done;

`ifdef LOADER_PARITY_EN
   logic r_error;
   logic w_parity_ok;

   assign w_parity_ok = (bs_data[0] == ^r_config_data);
   assign error       = r_error;
`else
   assign error       = 1'b0;
`endif

   always_comb begin
      w_state_nxt = r_state;
      bs_ready    = 1'b0;
      busy        = (r_state != S_IDLE);
      case (r_state)
         S_IDLE: begin
            if (w_start_ok) w_state_nxt = S_SHIFT;
         end
         S_SHIFT: begin
            bs_ready = 1'b1;
            if (bs_valid && (r_beat == c_LAST_BEAT)) begin
`ifdef LOADER_PARITY_EN
               w_state_nxt = S_PARITY;
`else
               w_state_nxt = S_COMMIT;
`endif
            end
         end
`ifdef LOADER_PARITY_EN
         S_PARITY: begin
            bs_ready = 1'b1;
            if (bs_valid) w_state_nxt = w_parity_ok ? S_COMMIT : S_DONE;
         end
`endif
         S_COMMIT: begin
            w_state_nxt = (r_idx == c_LAST_LUT) ? S_DONE : S_SHIFT;
         end
         S_DONE: begin
            w_state_nxt = S_IDLE;
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge config_clk or posedge config_rst) begin
      if (config_rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Commit strobe and done are registered so both leave the block glitch-free;
   // config_data still holds the frame during the strobe cycle.
   always_ff @(posedge config_clk or posedge config_rst) begin
      if (config_rst) begin
         r_beat        <= '0;
         r_idx         <= '0;
         r_config_data <= '0;
         r_config_en   <= '0;
         r_done        <= 1'b0;
`ifdef LOADER_PARITY_EN
         r_error       <= 1'b0;
`endif
      end else begin
         r_config_en <= '0;
         r_done      <= (r_state == S_DONE);
         case (r_state)
            S_IDLE: begin
               if (w_start_ok) begin
                  r_beat  <= '0;
                  r_idx   <= '0;
`ifdef LOADER_PARITY_EN
                  r_error <= 1'b0;
`endif
               end
            end
            S_SHIFT: begin
               if (bs_valid) begin
                  r_config_data[r_beat*CONFIG_WIDTH +: CONFIG_WIDTH] <= bs_data;
                  r_beat <= (r_beat == c_LAST_BEAT) ? '0 : r_beat + 1'b1;
               end
            end
`ifdef LOADER_PARITY_EN
            S_PARITY: begin
               if (bs_valid && !w_parity_ok) r_error <= 1'b1;
            end
`endif
            S_COMMIT: begin
               r_config_en <= c_EN_ONE << r_idx;
               if (r_idx != c_LAST_LUT) r_idx <= r_idx + 1'b1;
            end
            default: begin
            end
         endcase
      end
   end

   assign config_data = r_config_data;
   assign config_en   = r_config_en;
   assign done        = r_done;

endmodule
`default_nettype wire

// File: tb/tb_lut_config_loader.sv
`default_nettype none
// Bench for lut_config_loader: stimulus pushes expected commits/done into queues,
// a monitor pops and compares them whenever the DUT strobes config_en or done.
module tb_lut_config_loader;

   localparam int MEM_SIZE     = 16;
   localparam int CONFIG_WIDTH = 4;
   localparam int NUM_LUTS     = 4;
   localparam int WORDS        = 4;
`ifdef LOADER_PARITY_EN
   localparam int LAT = WORDS + 2;
`else
   localparam int LAT = WORDS + 1;
`endif

   logic                    config_clk = 1'b0;
   logic                    config_rst;
   logic                    start;
   logic                    bs_valid;
   logic [CONFIG_WIDTH-1:0] bs_data;
   logic                    bs_ready;
   logic [MEM_SIZE-1:0]     config_data;
   logic [NUM_LUTS-1:0]     config_en;
   logic                    busy;
   logic                    done;
   logic                    error;

   typedef struct {
      logic [NUM_LUTS-1:0] en;
      logic [MEM_SIZE-1:0] data;
      int                  rel;
   } commit_t;

   commit_t exp_q[$];
   int      done_q[$];
   int      checks = 0;
   int      errors = 0;
   int      cyc    = 0;
   int      t0     = 0;

   // Hand-assembled frames: beat k lands in nibble k.
   logic [3:0]  beats  [4][4] = '{'{4'h3, 4'hC, 4'h5, 4'hA},
                                  '{4'h4, 4'h3, 4'h2, 4'h1},
                                  '{4'hF, 4'hE, 4'hE, 4'hB},
                                  '{4'hF, 4'h0, 4'hF, 4'h0}};
   logic [15:0] frames [4]    = '{16'hA5C3, 16'h1234, 16'hBEEF, 16'h0F0F};
   logic        par    [4]    = '{1'b0, 1'b1, 1'b1, 1'b0};
   logic [3:0]  en_tab [4]    = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};

   lut_config_loader #(
      .MEM_SIZE    (MEM_SIZE),
      .CONFIG_WIDTH(CONFIG_WIDTH),
      .NUM_LUTS    (NUM_LUTS)
   ) dut (
      .config_clk (config_clk),
      .config_rst (config_rst),
      .start      (start),
      .bs_valid   (bs_valid),
      .bs_data    (bs_data),
      .bs_ready   (bs_ready),
      .config_data(config_data),
      .config_en  (config_en),
      .busy       (busy),
      .done       (done),
      .error      (error)
   );

   always #5 config_clk = ~config_clk;
   always @(posedge config_clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic push_commit(input int en_i, input int fr_i, input int rel);
      commit_t c;
      c.en   = en_tab[en_i];
      c.data = frames[fr_i];
      c.rel  = rel;
      exp_q.push_back(c);
   endtask

   task automatic do_start();
      start = 1'b1;
      @(negedge config_clk);
      start = 1'b0;
      t0    = cyc;
   endtask

   task automatic send_beat(input logic [3:0] d);
      int n = 0;
      bs_valid = 1'b1;
      bs_data  = d;
      while (!bs_ready && n < 50) begin
         @(negedge config_clk);
         n++;
      end
      if (!bs_ready) check("beat_accept_timeout", 32'(bs_ready), 32'd1);
      @(negedge config_clk);
      bs_valid = 1'b0;
   endtask

   task automatic send_raw(input logic [3:0] b0, input logic [3:0] b1, input logic [3:0] b2,
                           input logic [3:0] b3, input logic p, input int stall, input bit pulse);
      send_beat(b0);
      if (pulse) start = 1'b1;
      send_beat(b1);
      start = 1'b0;
      repeat (stall) @(negedge config_clk);
      send_beat(b2);
      send_beat(b3);
`ifdef LOADER_PARITY_EN
      send_beat({3'b000, p});
`else
      if (p === 1'bx) bs_data = '0;
`endif
   endtask

   task automatic send_lut(input int i, input int stall, input bit pulse);
      send_raw(beats[i][0], beats[i][1], beats[i][2], beats[i][3], par[i], stall, pulse);
   endtask

   task automatic wait_done(input bit start_at_done);
      int n = 0;
      while (done !== 1'b1 && n < 100) begin
         @(negedge config_clk);
         n++;
      end
      if (done !== 1'b1) check("done_timeout", 32'(done), 32'd1);
      if (start_at_done) start = 1'b1;
      @(negedge config_clk);
      start = 1'b0;
      @(negedge config_clk);
   endtask

   initial begin : monitor
      commit_t e;
      int      d;
      forever begin
         @(negedge config_clk);
         if (config_en !== '0) begin
            check("commit_onehot", 32'($countones(config_en)), 32'd1);
            if (exp_q.size() == 0) begin
               check("unexpected_commit", 32'(config_en), 32'd0);
            end else begin
               e = exp_q.pop_front();
               check("commit_en",    32'(config_en),   32'(e.en));
               check("commit_data",  32'(config_data), 32'(e.data));
               check("commit_cycle", 32'(cyc - t0),    32'(e.rel));
            end
         end
         if (done === 1'b1) begin
            if (done_q.size() == 0) begin
               check("unexpected_done", 32'(done), 32'd0);
            end else begin
               d = done_q.pop_front();
               check("done_cycle", 32'(cyc - t0), 32'(d));
            end
         end
      end
   end

   initial begin : stimulus
      config_rst = 1'b1;
      start      = 1'b0;
      bs_valid   = 1'b0;
      bs_data    = '0;
      repeat (2) @(negedge config_clk);
      check("rst_bs_ready",    32'(bs_ready),    32'd0);
      check("rst_config_data", 32'(config_data), 32'd0);
      check("rst_config_en",   32'(config_en),   32'd0);
      check("rst_busy",        32'(busy),        32'd0);
      check("rst_done",        32'(done),        32'd0);
      check("rst_error",       32'(error),       32'd0);
      config_rst = 1'b0;
      @(negedge config_clk);

      // Contiguous full load; start held through the done cycle must be ignored.
      do_start();
      check("busy_in_load", 32'(busy), 32'd1);
      for (int i = 0; i < NUM_LUTS; i++) push_commit(i, i, LAT * (i + 1));
      done_q.push_back(1 + NUM_LUTS * LAT);
      for (int i = 0; i < NUM_LUTS; i++) send_lut(i, 0, 1'b0);
      wait_done(1'b1);
      check("busy_after_done",   32'(busy),     32'd0);
      check("ready_after_done",  32'(bs_ready), 32'd0);
      check("error_after_load",  32'(error),    32'd0);
      check("data_held_idle",    32'(config_data), 32'h0F0F);

      // Three-cycle valid gap inside LUT 0 delays every commit by three.
      do_start();
      for (int i = 0; i < NUM_LUTS; i++) push_commit(i, 3 - i, LAT * (i + 1) + 3);
      done_q.push_back(1 + NUM_LUTS * LAT + 3);
      send_lut(3, 3, 1'b0);
      send_lut(2, 0, 1'b0);
      send_lut(1, 0, 1'b0);
      send_lut(0, 0, 1'b0);
      wait_done(1'b0);

      // Start pulse during LUT 1 shifting has no effect.
      do_start();
      for (int i = 0; i < NUM_LUTS; i++) push_commit(i, i, LAT * (i + 1));
      done_q.push_back(1 + NUM_LUTS * LAT);
      send_lut(0, 0, 1'b0);
      send_lut(1, 0, 1'b1);
      send_lut(2, 0, 1'b0);
      send_lut(3, 0, 1'b0);
      wait_done(1'b0);

      // Reset two beats into LUT 2: outputs clear at once and LUT 2 is never strobed.
      do_start();
      push_commit(0, 0, LAT);
      push_commit(1, 1, 2 * LAT);
      send_lut(0, 0, 1'b0);
      send_lut(1, 0, 1'b0);
      send_beat(beats[2][0]);
      send_beat(beats[2][1]);
      config_rst = 1'b1;
      #1;
      check("midrst_config_en",   32'(config_en),   32'd0);
      check("midrst_config_data", 32'(config_data), 32'd0);
      check("midrst_busy",        32'(busy),        32'd0);
      check("midrst_bs_ready",    32'(bs_ready),    32'd0);
      repeat (3) @(negedge config_clk);
      check("midrst_commits_seen", 32'(exp_q.size()), 32'd0);
      config_rst = 1'b0;
      do_start();
      push_commit(0, 1, LAT);
      push_commit(1, 2, 2 * LAT);
      push_commit(2, 3, 3 * LAT);
      push_commit(3, 0, 4 * LAT);
      done_q.push_back(1 + NUM_LUTS * LAT);
      send_lut(1, 0, 1'b0);
      send_lut(2, 0, 1'b0);
      send_lut(3, 0, 1'b0);
      send_lut(0, 0, 1'b0);
      wait_done(1'b0);

`ifdef LOADER_PARITY_EN
      // Frame 16'h0001 has odd weight: parity beat 0 is a mismatch.
      do_start();
      done_q.push_back(WORDS + 2);
      send_raw(4'h1, 4'h0, 4'h0, 4'h0, 1'b0, 0, 1'b0);
      wait_done(1'b0);
      check("parity_error_set", 32'(error), 32'd1);
      do_start();
      check("parity_error_clr", 32'(error), 32'd0);
      begin
         commit_t c;
         c.en   = 4'b0001;
         c.data = 16'h0001;
         c.rel  = LAT;
         exp_q.push_back(c);
      end
      for (int i = 1; i < NUM_LUTS; i++) push_commit(i, i, LAT * (i + 1));
      done_q.push_back(1 + NUM_LUTS * LAT);
      send_raw(4'h1, 4'h0, 4'h0, 4'h0, 1'b1, 0, 1'b0);
      for (int i = 1; i < NUM_LUTS; i++) send_lut(i, 0, 1'b0);
      wait_done(1'b0);
      check("parity_ok_error", 32'(error), 32'd0);
`endif

      repeat (3) @(negedge config_clk);
      check("pending_commits", 32'(exp_q.size()),  32'd0);
      check("pending_done",    32'(done_q.size()), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
